// File: rtl/subtract.sv
// Registered unsigned subtractor: c = |a - b|, sign = (a < b); 1-cycle latency.
// No backpressure: operands are sampled on every rising clk edge.
module subtract #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             sign
);

  logic [WIDTH:0]   brw;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] inv;
  logic [WIDTH-1:0] inc_c;
  logic [WIDTH-1:0] neg;
  logic [WIDTH-1:0] mag;
  logic             borrow;

  assign brw[0]   = 1'b0;
  assign inc_c[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      // Full subtractor cell: diff and borrow-out ripple toward the MSB.
      assign diff[i]  = a[i] ^ b[i] ^ brw[i];
      assign brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);

      // Two's-complement negation: increment of the inverted difference.
      assign inv[i] = ~diff[i];
      assign neg[i] = inv[i] ^ inc_c[i];
      if (i < WIDTH - 1) begin : g_inc
        assign inc_c[i+1] = inv[i] & inc_c[i];
      end
    end
  endgenerate

  assign borrow = brw[WIDTH];
  assign mag    = borrow ? neg : diff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c    <= '0;
      sign <= 1'b0;
    end else begin
      c    <= mag;
      sign <= borrow;
    end
  end

endmodule

// File: tb/tb_subtract.sv
// Directed bench for subtract: reset, extremes, streaming, async reset, and a WIDTH=4 sweep.
module tb_subtract;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] c;
  logic       sign;
  logic [3:0] a4;
  logic [3:0] b4;
  logic [3:0] c4;
  logic       sign4;

  int n_cmp;
  int n_err;

  subtract #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .c     (c),
    .sign  (sign)
  );

  subtract #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .a     (a4),
    .b     (b4),
    .c     (c4),
    .sign  (sign4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0;
    a = 8'h6f;
    b = 8'had;
    #1;
    n_cmp++;
    if (c !== 8'h00 || sign !== 1'b0) begin
      n_err++;
      $display("FAIL reset_initial: c=%h sign=%b, want c=00 sign=0", c, sign);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (c !== 8'h00 || sign !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold%0d: c=%h sign=%b, want c=00 sign=0", k, c, sign);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (c !== 8'h00 || sign !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_pre_edge: c=%h sign=%b, want c=00 sign=0", c, sign);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (c !== 8'h3e || sign !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_capture: c=%h sign=%b, want c=3e sign=1", c, sign);
    end
  endtask

  task automatic test_positive();
    @(negedge clk);
    a = 8'had;
    b = 8'h6f;
    #1;
    n_cmp++;
    if (c !== 8'h3e || sign !== 1'b1) begin
      n_err++;
      $display("FAIL positive_pre_edge: c=%h sign=%b, want c=3e sign=1", c, sign);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (c !== 8'h3e || sign !== 1'b0) begin
      n_err++;
      $display("FAIL positive: c=%h sign=%b, want c=3e sign=0", c, sign);
    end
  endtask

  task automatic test_extremes();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic [7:0] vc [5];
    logic       vs [5];
    va = '{8'h55, 8'h00, 8'hff, 8'h80, 8'hff};
    vb = '{8'h55, 8'hff, 8'h00, 8'h81, 8'hff};
    vc = '{8'h00, 8'hff, 8'hff, 8'h01, 8'h00};
    vs = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a = va[k];
      b = vb[k];
      @(posedge clk);
      #1;
      n_cmp++;
      if (c !== vc[k] || sign !== vs[k]) begin
        n_err++;
        $display("FAIL extreme%0d a=%h b=%h: c=%h sign=%b, want c=%h sign=%b",
                 k, va[k], vb[k], c, sign, vc[k], vs[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] ec;
    logic       es;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ea = 8'($urandom_range(0, 255));
      eb = 8'($urandom_range(0, 255));
      if (k == 0) eb = ea + 8'd1;
      a  = ea;
      b  = eb;
      es = (ea < eb);
      ec = es ? (eb - ea) : (ea - eb);
      @(posedge clk);
      #1;
      n_cmp++;
      if (c !== ec || sign !== es) begin
        n_err++;
        $display("FAIL b2b%0d a=%h b=%h: c=%h sign=%b, want c=%h sign=%b",
                 k, ea, eb, c, sign, ec, es);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = 8'hff;
    b = 8'h00;
    @(posedge clk);
    #1;
    n_cmp++;
    if (c !== 8'hff || sign !== 1'b0) begin
      n_err++;
      $display("FAIL async_setup: c=%h sign=%b, want c=ff sign=0", c, sign);
    end
    @(negedge clk);
    a = 8'h00;
    b = 8'h01;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (c !== 8'h00 || sign !== 1'b0) begin
      n_err++;
      $display("FAIL async_clear: c=%h sign=%b, want c=00 sign=0", c, sign);
    end
    a = 8'h10;
    b = 8'h30;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (c !== 8'h20 || sign !== 1'b1) begin
      n_err++;
      $display("FAIL async_recapture: c=%h sign=%b, want c=20 sign=1", c, sign);
    end
  endtask

  task automatic test_exhaustive4();
    logic [3:0] ec;
    logic       es;
    int         bad;
    bad = 0;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        @(negedge clk);
        a4 = 4'(ia);
        b4 = 4'(ib);
        es = (ia < ib);
        ec = es ? 4'(ib - ia) : 4'(ia - ib);
        @(posedge clk);
        #1;
        n_cmp++;
        if (c4 !== ec || sign4 !== es) begin
          n_err++;
          bad++;
          if (bad <= 8)
            $display("FAIL w4 a=%h b=%h: c=%h sign=%b, want c=%h sign=%b",
                     ia[3:0], ib[3:0], c4, sign4, ec, es);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    a4 = 4'h0;
    b4 = 4'h0;
    test_reset();
    test_positive();
    test_extremes();
    test_back_to_back();
    test_async_reset();
    test_exhaustive4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/subtract.md
Name: subtract

Overview:
- Registered unsigned subtractor producing a sign-magnitude result: c = |a - b|, and sign flags a < b.
- Sits in the 8-bit computer datapath beside the adder in the arithmetic library. It feeds the ALU result mux and the flags logic.
- Operands are sampled on every rising clock edge. There is no enable and no handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  system clock; rising-edge active.
- reset  input  1  asynchronous, active-low reset; 0 clears all outputs.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- c  output  WIDTH  registered magnitude |a - b|, unsigned.
- sign  output  1  registered sign; 1 when a < b (result negative), else 0.

Behaviour:
- Reset:
  - reset = 0 forces c = 0 and sign = 0 immediately, independent of clk.
  - Outputs hold these values while reset is low.
  - The first capture is on the first rising clk edge after reset returns to 1.
  - Reset asserted mid-operation discards the pending result. No state survives reset.
- Datapath, combinational:
  - Form d = a + ~b + 1 over WIDTH+1 bits, i.e. a ripple-borrow subtract.
  - borrow = NOT carry-out, which equals (a < b).
  - If borrow = 0: mag = d[WIDTH-1:0].
  - If borrow = 1: mag = two's-complement negation of d[WIDTH-1:0].
- Register stage:
  - On each rising clk edge with reset = 1: c <= mag and sign <= borrow.
  - Latency is exactly 1 cycle. Throughput is 1 result per cycle.
  - Inputs changing between edges have no effect on the outputs until the next edge.
- Arithmetic rules:
  - Operands are unsigned only. The output range of c is 0 .. 2^WIDTH-1.
  - No overflow is possible: |a - b| <= 2^WIDTH-1 always fits in c.
  - Negative zero is never produced. a == b gives c = 0, sign = 0.
- Boundary cases:
  - a = 0, b = max: c = max, sign = 1.
  - a = max, b = 0: c = max, sign = 0.
  - a = b = max: c = 0, sign = 0.
  - b = a + 1: c = 1, sign = 1.
- X handling: no X on c or sign once reset has been applied, provided the inputs are known at the sampling edge.
- Implementation:
  - Build the subtract from a generate-loop chain of 1-bit full subtractor cells (diff, borrow_out), not a behavioural "-" operator.
  - Conditional negation is a second ripple incrementer over the inverted difference, selected by borrow through a 2:1 mux.
  - One output register bank with asynchronous clear.

Test Plan:
- Reset: hold reset = 0 with a = 8'h6f, b = 8'had and toggle clk -> c = 8'h00, sign = 0 throughout. Release reset -> after 1 edge, c = 8'h3e, sign = 1.
- Positive result: a = 8'had, b = 8'h6f -> next edge c = 8'h3e, sign = 0. Outputs must not change before that edge.
- Equality and extremes, one per cycle:
  - a = b = 8'h55 -> c = 8'h00, sign = 0.
  - a = 8'h00, b = 8'hff -> c = 8'hff, sign = 1.
  - a = 8'hff, b = 8'h00 -> c = 8'hff, sign = 0.
  - a = 8'h80, b = 8'h81 -> c = 8'h01, sign = 1.
- Back-to-back throughput: change the operands every cycle over 20 random pairs -> each result appears exactly 1 cycle after its operands, with no skipped or repeated results.
- Asynchronous reset mid-stream: assert reset = 0 between clock edges while the outputs are nonzero -> c and sign clear immediately, without waiting for a clk edge. Deassert reset -> the next edge captures the current a, b.
- Exhaustive at WIDTH = 4: sweep all 256 (a, b) pairs -> c == |a - b| and sign == (a < b) for every pair, checked against a reference model.
